sevenseg_scan_bcd: RTL
======================

// Module: sevenseg_scan_bcd
// PURPOSE
//   Parametrised multiplexed 7-segment driver for the CPU's output-register display. Accepts a
//   WIDTH-bit unsigned value with a load strobe and converts it to NUM_DIGITS digits:
//   decimal via sequential double-dabble, or hex. Scans the digits one at a time with
//   leading-zero blanking, overflow indication and selectable output polarity.
// PARAMETERS
//   WIDTH          8     input value width, 4..16
//   NUM_DIGITS     4     number of display digits, 1..6
//   REFRESH_DIV    5000  clk cycles per digit slot, >=2
//   SEG_ACTIVE_LOW 1     1: segment lit = 0; 0: segment lit = 1
//   SEL_ACTIVE_LOW 0     1: selected digit driven 0; 0: selected digit driven 1
// PORTS
//   clk          in   1           system clock
//   rst          in   1           synchronous reset, active-high
//   value        in   WIDTH       number to display
//   value_valid  in   1           load strobe, one cycle
//   hex_mode     in   1           sampled at accept; 1 = hex digits, 0 = decimal
//   blank_lz     in   1           live input; 1 = blank leading zeros
//   busy         out  1           conversion in progress
//   segments     out  7           {a,b,c,d,e,f,g}, a = MSB; registered
//   digit_sel    out  NUM_DIGITS  one-hot digit enable; bit0 = rightmost (least significant) digit; registered
// BEHAVIOUR
// - Reset:
//   - busy = 0, scan index = 0, refresh counter = 0, pending flag clear.
//   - Display register = all-zero digits, not overflowed.
//   - segments = all off and digit_sel = none selected, both in the active polarity.
// - Accept:
//   - value_valid with busy = 0 and no pending request: capture value and hex_mode this cycle.
//   - busy = 1 from the next cycle for exactly WIDTH cycles.
//   - Display register updates atomically on the edge where busy falls. Latency from strobe to new digits is WIDTH+1 cycles.
//   - value_valid while busy: value/hex_mode go to a one-deep pending slot, newest wins.
//     Conversion starts the cycle after busy falls, with no idle cycle in between.
// - FSM states:
//   - IDLE -> CONVERT on accept or pending.
//   - CONVERT runs WIDTH shift steps: add 3 to each BCD nibble >= 5, then shift left 1.
//   - CONVERT -> COMMIT is folded into the final shift edge.
//   - Hex mode follows the same timing: nibbles are taken directly, no add-3.
// - Overflow (evaluated on the captured value):
//   - decimal: value > 10^NUM_DIGITS - 1.
//   - hex: value >= 16^NUM_DIGITS.
//   - On overflow every digit shows '-' (segment g only). blank_lz is ignored.
// - Scan:
//   - Refresh counter counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and the scan index advances.
//   - Scan index wraps NUM_DIGITS-1 -> 0 (no dead slot).
//   - segments and digit_sel both change on the same edge, one cycle after the index changes.
//   - Conversion never stalls the scan.
// - Blanking:
//   - With blank_lz = 1, every digit above the most significant nonzero digit is off.
//   - digit 0 is always shown, so value 0 displays "0".
// - Glyphs (active-low form): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//   6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010
//   E=0110000 F=0111000 '-'=1111110 blank=1111111. Invert all bits when SEG_ACTIVE_LOW = 0.
// - rst mid-conversion: abort, discard pending, and return the display to reset contents.
// TESTING
// - WIDTH=8, NUM_DIGITS=4, REFRESH_DIV=4; rst 3 cycles -> segments=7F, digit_sel=0;
//   next slot digit0 shows "0".
// - value=8'd255 strobe, hex_mode=0, blank_lz=1 -> busy high 8 cycles; digits 3..0 = blank,2,5,5;
//   digit_sel walks 0001,0010,0100,1000,0001 every 4 clocks.
// - value=8'hA7, hex_mode=1, blank_lz=0 -> digits 0,0,A,7; segments for digit1 = 0001000.
// - NUM_DIGITS=2, value=8'd100 decimal -> both digits show 1111110 (overflow).
// - Strobe 8'd12, then 8'd34 and 8'd56 while busy -> display shows 12, then 56;
//   34 never displayed; second conversion starts the cycle after busy falls.
// - rst asserted on the 4th cycle of a conversion -> busy=0 next cycle; pending cleared;
//   display returns to reset contents.

Source files
------------

// File: rtl/sevenseg_scan_bcd.sv
// sevenseg_scan_bcd: multiplexed 7-segment driver, sequential double-dabble
// (or hex) conversion, leading-zero blanking, overflow dashes, polarity select.
// Ports: clk, rst (sync, active-high); value/value_valid/hex_mode load a number;
// blank_lz live blanking enable; busy during conversion; segments {a..g}
// and one-hot digit_sel (bit0 = rightmost), both registered.
module sevenseg_scan_bcd #(
  parameter int WIDTH          = 8,
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 5000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  value_valid,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_sel
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] DEC_MAX = 32'(10 ** NUM_DIGITS - 1);
  localparam logic [31:0] HEX_LIM = 32'd1 << DW;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_NONE = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [DW-1:0]    bcd_q, bcd_d;
  logic             hex_q, ovf_q;
  logic             pend_q, pend_hex_q;
  logic [WIDTH-1:0] pend_val_q;
  logic [DW-1:0]    disp_q;
  logic             disp_ovf_q;
  logic [RW-1:0]    ref_q;
  logic [IW-1:0]    idx_q;
  logic [6:0]       seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic             start;
  logic [WIDTH-1:0] cap_val;
  logic             cap_hex, cap_ovf;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // A fresh strobe outranks a pending request taken in the same cycle.
  always_comb begin
    start   = (state_q == IDLE) && (value_valid || pend_q);
    cap_val = value_valid ? value : pend_val_q;
    cap_hex = value_valid ? hex_mode : pend_hex_q;
    if (cap_hex) cap_ovf = 32'(cap_val) >= HEX_LIM;
    else         cap_ovf = 32'(cap_val) > DEC_MAX;
  end

  // One double-dabble step; hex mode just shifts bits into the nibbles.
  always_comb begin
    logic [DW-1:0] adj;
    adj = bcd_q;
    if (!hex_q) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_d = {adj[DW-2:0], sh_q[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
      bcd_q      <= '0;
      hex_q      <= 1'b0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_hex_q <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      if (value_valid && state_q == CONVERT) begin
        pend_q     <= 1'b1;
        pend_val_q <= value;
        pend_hex_q <= hex_mode;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CONVERT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= cap_val;
            bcd_q   <= '0;
            hex_q   <= cap_hex;
            ovf_q   <= cap_ovf;
            pend_q  <= 1'b0;
          end
        end
        CONVERT: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
          // Last shift commits straight into the display register.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            disp_q     <= bcd_d;
            disp_ovf_q <= ovf_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic [3:0]            cur;
    logic [IW-1:0]         msd;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            g;
    cur    = '0;
    msd    = '0;
    onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_q[4*k +: 4] != 4'd0) msd = IW'(k);
      if (idx_q == IW'(k)) begin
        cur       = disp_q[4*k +: 4];
        onehot[k] = 1'b1;
      end
    end
    if (disp_ovf_q)                   g = 7'b1111110;
    else if (blank_lz && idx_q > msd) g = 7'b1111111;
    else                              g = glyph(cur);
    seg_d = SEG_ACTIVE_LOW ? g : ~g;
    sel_d = SEL_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      sel_q <= SEL_NONE;
    end else begin
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign busy      = busy_q;
  assign segments  = seg_q;
  assign digit_sel = sel_q;

endmodule
